// File: rtl/lcd_print_arbiter_if.sv
// Request/print bus between the two requesters and the LCD print arbiter.
// The master side holds the requesters; the slave side is the arbiter and its LCD outputs.
interface lcd_print_arbiter_if;
    logic       req0;
    logic [7:0] val0;
    logic       req1;
    logic [7:0] val1;
    logic       ack0;
    logic       ack1;
    logic       busy;
    logic       overflow;
    logic       lcd_sign;
    logic [3:0] lcd_digit1;
    logic [3:0] lcd_digit2;
    logic       lcd_disable;

    modport master (
        output req0, val0, req1, val1,
        input  ack0, ack1, busy, overflow,
        input  lcd_sign, lcd_digit1, lcd_digit2, lcd_disable
    );

    modport slave (
        input  req0, val0, req1, val1,
        output ack0, ack1, busy, overflow,
        output lcd_sign, lcd_digit1, lcd_digit2, lcd_disable
    );
endinterface

// File: rtl/lcd_print_arbiter.sv
// Two-requester arbiter for the signed two-digit LCD print path: grant, convert to sign+BCD, hold window.
// Build option: define LCD_ARB_FIXED_PRIORITY_EN to make req0 always win ties instead of round-robin.
module lcd_print_arbiter #(
    parameter int unsigned HOLD_CYCLES = 2500000,
    parameter int unsigned CNT_W       = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    lcd_print_arbiter_if.slave  bus
);

    localparam int unsigned HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_PRINT,
        ST_RELEASE
    } state_t;

    state_t            state;
    logic              first;
    logic [7:0]        val_q;
    logic              sign_q;
    logic              ovf_q;
    logic [6:0]        rem_q;
    logic [3:0]        tens_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_grant;

    logic              ack0_q;
    logic              ack1_q;
    logic              busy_q;
    logic              overflow_q;
    logic              lcd_sign_q;
    logic [3:0]        lcd_digit1_q;
    logic [3:0]        lcd_digit2_q;
    logic              lcd_disable_q;

    logic              grant1;
    logic [7:0]        mag;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant1 = 1'b0;
`ifdef LCD_ARB_FIXED_PRIORITY_EN
        grant1 = bus.req1 && !bus.req0;
`else
        // On a tie, the requester that did not win last time gets the path.
        grant1 = bus.req1 && (!bus.req0 || !last_grant);
`endif
    end

    // -128 has no positive 8-bit signed form; read as unsigned it is 128, which clamps anyway.
    assign mag = val_q[7] ? (~val_q + 8'd1) : val_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            first         <= 1'b0;
            val_q         <= 8'd0;
            sign_q        <= 1'b0;
            ovf_q         <= 1'b0;
            rem_q         <= 7'd0;
            tens_q        <= 4'd0;
            cnt_q         <= '0;
            last_grant    <= 1'b1;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
            lcd_sign_q    <= 1'b0;
            lcd_digit1_q  <= 4'd0;
            lcd_digit2_q  <= 4'd0;
            lcd_disable_q <= 1'b1;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    lcd_disable_q <= 1'b1;
                    if (bus.req0 || bus.req1) begin
                        state      <= ST_CONVERT;
                        first      <= 1'b1;
                        busy_q     <= 1'b1;
                        ack0_q     <= !grant1;
                        ack1_q     <= grant1;
                        last_grant <= grant1;
                        val_q      <= grant1 ? bus.val1 : bus.val0;
                    end
                end

                ST_CONVERT: begin
                    if (first) begin
                        first  <= 1'b0;
                        sign_q <= val_q[7];
                        tens_q <= 4'd0;
                        if (mag > 8'd99) begin
                            rem_q <= 7'd99;
                            ovf_q <= 1'b1;
                        end else begin
                            rem_q <= mag[6:0];
                            ovf_q <= 1'b0;
                        end
                    end else if (rem_q >= 7'd10) begin
                        // Repeated subtraction: at most nine steps for a clamped magnitude.
                        rem_q  <= rem_q - 7'd10;
                        tens_q <= tens_q + 4'd1;
                    end else begin
                        lcd_sign_q    <= sign_q;
                        lcd_digit1_q  <= tens_q;
                        lcd_digit2_q  <= rem_q[3:0];
                        overflow_q    <= ovf_q;
                        lcd_disable_q <= 1'b0;
                        cnt_q         <= '0;
                        state         <= ST_PRINT;
                    end
                end

                ST_PRINT: begin
                    if (cnt_q == HOLD_LAST) begin
                        lcd_disable_q <= 1'b1;
                        state         <= ST_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state         <= ST_IDLE;
                    busy_q        <= 1'b0;
                    lcd_disable_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.busy        = busy_q;
    assign bus.overflow    = overflow_q;
    assign bus.lcd_sign    = lcd_sign_q;
    assign bus.lcd_digit1  = lcd_digit1_q;
    assign bus.lcd_digit2  = lcd_digit2_q;
    assign bus.lcd_disable = lcd_disable_q;

endmodule

// File: tb/tb_lcd_print_arbiter.sv
// Randomized bench for lcd_print_arbiter with a behavioural print/arbitration model (HOLD_CYCLES=4).
module tb_lcd_print_arbiter;

    localparam int HOLD = 4;
`ifdef LCD_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_print_arbiter_if bus ();

    lcd_print_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit exp_last  = 1'b1;
    bit hold_reqs = 1'b0;
    bit poke      = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // What the LCD should show for a value: sign, clamped tens/units, overflow flag.
    task automatic model(input logic [7:0] v, output int sg, output int tens,
                         output int units, output int ovf);
        int s, m;
        s = int'($signed(v));
        m = (s < 0) ? -s : s;
        ovf = (m > 99) ? 1 : 0;
        if (m > 99) m = 99;
        sg = (s < 0) ? 1 : 0;
        tens = m / 10;
        units = m % 10;
    endtask

    task automatic pick_val(output logic [7:0] v);
        case ($urandom_range(0, 6))
            0: v = 8'd99;
            1: v = 8'd100;
            2: v = 8'h80;
            3: v = 8'd0;
            4: v = 8'h9D;
            5: v = 8'h9C;
            default: v = 8'($urandom);
        endcase
    endtask

    // Raise / retarget the requester that is waiting while the path is busy.
    task automatic nudge_other(input bit win);
        logic [7:0] v;
        if (hold_reqs || !poke) return;
        pick_val(v);
        if (win) begin
            bus.req0 = 1'b1;
            bus.val0 = v;
        end else begin
            bus.req1 = 1'b1;
            bus.val1 = v;
        end
    endtask

    // Called at a falling edge with requests already driven; follows one full transaction.
    task automatic serve();
        int n, m, k;
        bit win, stray, unstable;
        logic [7:0] v, nv;
        int esign, etens, eunits, eovf;
        logic sg;
        logic [3:0] d1, d2;
        logic of;

        stray = 1'b0;
        unstable = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) break;
        end
        check("ack_latency", n, 1);
        if (!(bus.ack0 || bus.ack1)) return;

        win = (bus.req0 && bus.req1) ? (FIXED ? 1'b0 : !exp_last) : !bus.req0;
        check("ack_winner", {bus.ack1, bus.ack0}, win ? 2 : 1);
        check("busy_on_ack", bus.busy, 1);
        exp_last = win;
        v = win ? bus.val1 : bus.val0;
        model(v, esign, etens, eunits, eovf);

        // Latched value must not follow later changes on the winner's input.
        pick_val(nv);
        if (win) begin
            bus.val1 = nv;
            if (!hold_reqs) bus.req1 = 1'b0;
        end else begin
            bus.val0 = nv;
            if (!hold_reqs) bus.req0 = 1'b0;
        end
        nudge_other(win);

        m = 0;
        while (bus.lcd_disable && m < 15) begin
            @(negedge clk);
            m++;
            if (bus.ack0 || bus.ack1) stray = 1'b1;
        end
        check("convert_latency_le_11", (m >= 1 && m <= 11), 1);
        if (bus.lcd_disable) return;

        check("lcd_sign", bus.lcd_sign, esign);
        check("lcd_digit1", bus.lcd_digit1, etens);
        check("lcd_digit2", bus.lcd_digit2, eunits);
        check("overflow", bus.overflow, eovf);
        sg = bus.lcd_sign;
        d1 = bus.lcd_digit1;
        d2 = bus.lcd_digit2;
        of = bus.overflow;
        nudge_other(win);

        k = 1;
        while (k < 30) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) stray = 1'b1;
            if (bus.lcd_disable) break;
            k++;
            if (bus.lcd_sign !== sg || bus.lcd_digit1 !== d1 ||
                bus.lcd_digit2 !== d2 || bus.overflow !== of) unstable = 1'b1;
        end
        check("print_window_cycles", k, HOLD);
        check("busy_in_release", bus.busy, 1);
        @(negedge clk);
        if (bus.ack0 || bus.ack1) stray = 1'b1;
        check("busy_fall", bus.busy, 0);
        check("disable_after_release", bus.lcd_disable, 1);
        check("no_stray_ack", stray, 0);
        check("outputs_stable", unstable, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] v;

        rst_n = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.val0 = 8'd0;
        bus.val1 = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_disable", bus.lcd_disable, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_acks", {bus.ack1, bus.ack0}, 0);
        check("rst_digits", {bus.lcd_sign, bus.lcd_digit1, bus.lcd_digit2, bus.overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values.
        bus.req0 = 1'b1; bus.val0 = 8'd37;  serve();
        bus.req1 = 1'b1; bus.val1 = 8'hF9;  serve();
        bus.req1 = 1'b1; bus.val1 = 8'h80;  serve();
        bus.req1 = 1'b1; bus.val1 = 8'd0;   serve();
        bus.req0 = 1'b1; bus.val0 = 8'd99;  serve();
        bus.req0 = 1'b1; bus.val0 = 8'd100; serve();

        // Requester 1 arrives while requester 0 is being served.
        poke = 1'b1;
        bus.req0 = 1'b1; bus.val0 = 8'd42;
        serve();
        poke = 1'b0;
        serve();

        // Both held high continuously.
        hold_reqs = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.val0 = 8'd11; bus.val1 = 8'hF5;
        repeat (4) serve();
        hold_reqs = 1'b0;
        bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.val0 = 8'd37;

        // Reset during the second print cycle.
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) break;
        end
        check("rst_case_ack_seen", bus.ack0, 1);
        for (n = 0; n < 20 && bus.lcd_disable; n++) @(negedge clk);
        check("rst_case_print_open", bus.lcd_disable, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_disable", bus.lcd_disable, 1);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_digits", {bus.lcd_sign, bus.lcd_digit1, bus.lcd_digit2, bus.overflow}, 0);
        repeat (2) @(negedge clk);
        check("rst_held_no_ack", {bus.ack1, bus.ack0}, 0);
        rst_n = 1'b1;
        exp_last = 1'b1;
        serve();

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            poke = ($urandom_range(0, 2) == 0);
            if (!bus.req0 && $urandom_range(0, 1) == 1) begin
                bus.req0 = 1'b1;
                pick_val(v);
                bus.val0 = v;
            end
            if (!bus.req1 && $urandom_range(0, 1) == 1) begin
                bus.req1 = 1'b1;
                pick_val(v);
                bus.val1 = v;
            end
            if (!bus.req0 && !bus.req1) begin
                pick_val(v);
                if ($urandom_range(0, 1) == 1) begin
                    bus.req1 = 1'b1;
                    bus.val1 = v;
                end else begin
                    bus.req0 = 1'b1;
                    bus.val0 = v;
                end
            end
            serve();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
